cs0_bus_sched: RTL
==================

Name: cs0_bus_sched

Overview:
Bus scheduler for the shared CS0 bus, whose default owner is the master SH-2. The slave SH-2 and the SCU can each request the bus; the block hands it to one of them and returns it to the master. It also generates per-region wait states for every access made by the current owner. It sits between the SH-2 bus-request pins, the SCU external-request pins and the memory wait logic.

Parameters:
DRAM_WS, 4'd5, wait CE_R ticks for LWRAM accesses (A[24:21]==4'b0001)
ROM_WS, 4'd6, wait CE_R ticks for any other CS0 access
HOLD_MAX, 8'd64, CE_R ticks a non-master owner may keep the bus while the other requester waits

Ports:
CLK  in  1  system clock
RST_N  in  1  async reset, active low
CE_R  in  1  rising-phase clock enable
CE_F  in  1  falling-phase clock enable
RES_N  in  1  sync soft reset, active low
SREQ_N  in  1  slave SH-2 bus request
XREQ_N  in  1  SCU bus request
BGR_N  in  1  master SH-2 bus grant (master has released the bus)
BRLS_N  out  1  release request to master
SACK_N  out  1  slave acknowledge
XACK_N  out  1  SCU acknowledge
OWNER  out  2  0=master, 1=slave, 2=SCU, 3=gap
A  in  24:21  access address, high bits
CS0_N  in  1  CS0 select
STRB_N  in  1  combined RD_N & WE_N strobe, low during an access
FAST  in  1  zero-wait mode
WAIT_N  out  1  wait to current owner, active low

Behaviour:
Reset (RST_N low, or RES_N low sampled on CLK):
- state MST; counters 0
- BRLS_N=1, SACK_N=1, XACK_N=1, OWNER=0, WAIT_N=1

Scheduler FSM, advancing only on CE_R:
- MST: BRLS_N = SREQ_N & XREQ_N.
  - If a request is pending and BGR_N=0, go to the winner state.
  - Fixed priority: slave beats SCU.
  - If the request drops before BGR_N goes low, stay in MST.
- SSH / SCU:
  - The matching ACK_N is 0 from the cycle after entry.
  - HOLD_CNT increments each CE_R while the other requester is pending, saturating at HOLD_MAX.
  - Leave when the own REQ_N=1, or when HOLD_CNT==HOLD_MAX with no access in flight (STRB_N=1 and WAIT_CNT==0).
  - On leaving, go to GAP and clear HOLD_CNT.
- GAP: both ACKs high for exactly one CE_R. Then:
  - go to the other requester if it is still pending (BGR_N still 0);
  - else, if the requester that just left is still asserting, go back to it;
  - else go to MST.
- An ACK is never dropped in the middle of an access. A forced handover waits until WAIT_CNT==0 and STRB_N=1.

Wait generator (per CLK):
- Start of access = STRB_N falling edge while CS0_N=0 (previous STRB_N kept in a register).
- On start, WAIT_N goes low and WAIT_CNT is loaded with DRAM_WS-1 or ROM_WS-1, selected by A.
- WAIT_CNT decrements on CE_R while nonzero.
- When WAIT_CNT==0, WAIT_N returns to 1 on the next CE_F.
- FAST=1: no load, WAIT_N stays 1.
- A new start while counting reloads the counter (restart).
- A parameter value of 0 is treated as 1.

Simultaneous events:
- SREQ_N and XREQ_N falling in the same cycle in MST: slave wins.
- RES_N low mid-access: immediate return to MST, WAIT_N=1.

Optional Feature:
CS0_ARB_RR_EN:
- Defined: the winner in MST is round-robin; the requester that did not own the bus last wins a tie. A last-winner flag resets to "SCU" so that the slave wins the first tie.
- Undefined: fixed slave priority, and the flag logic is absent.

Decomposition:
- Package cs0_sched_pkg:
  - owner_t enum: MST, SSH, SCU, GAP
  - region-decode constant LWRAM_A = 4'b0001
  - default wait constants
- One sub-module, cs0_wait_gen: strobe edge detect, counter, WAIT_N. The FSM stays in the top module.

Test Plan:
- Slave request: SREQ_N=0 → BRLS_N=0 next CE_R; drive BGR_N=0 → SACK_N=0 on the following CE_R, OWNER=1; SREQ_N=1 → GAP for 1 CE_R, then MST, BRLS_N=1.
- Simultaneous SREQ_N/XREQ_N=0 → slave granted first. With CS0_ARB_RR_EN, a second tie after a slave tenure → SCU granted.
- Hold limit: slave holds, SCU pending, HOLD_MAX=8 → SACK_N=1 after 8 CE_R, one GAP, then XACK_N=0. An access in flight at the limit delays the handover until WAIT_N=1.
- Wait states: A=0001 access, DRAM_WS=5 → WAIT_N low for 5 CE_R plus the CE_F edge; A=0000, ROM_WS=6 → 6. FAST=1 → WAIT_N never low.
- Reset mid-tenure: SCU owns, WAIT_N low, RES_N=0 → next CLK gives OWNER=0, XACK_N=1, WAIT_N=1, BRLS_N=1.
- Request withdrawn: SREQ_N pulses low for 2 CE_R with BGR_N=1 → no ACK, FSM stays in MST, BRLS_N returns to 1.

Source files
------------

// File: rtl/cs0_sched_pkg.sv
// Shared types and constants for the CS0 bus scheduler and its wait generator.
package cs0_sched_pkg;

    typedef enum logic [1:0] {
        MST = 2'd0,
        SSH = 2'd1,
        SCU = 2'd2,
        GAP = 2'd3
    } owner_t;

    localparam logic [3:0] LWRAM_A      = 4'b0001;
    localparam logic [3:0] DRAM_WS_DEF  = 4'd5;
    localparam logic [3:0] ROM_WS_DEF   = 4'd6;
    localparam logic [7:0] HOLD_MAX_DEF = 8'd64;

    // Counter preload for a wait-state count; zero behaves like one.
    function automatic logic [3:0] ws_load(input logic [3:0] ws);
        return (ws == 4'd0) ? 4'd0 : ws - 4'd1;
    endfunction

endpackage

// File: rtl/cs0_wait_gen.sv
// CS0 wait-state generator: detects access start on the strobe falling edge and
// holds WAIT_N low until the region-dependent count expires on a falling-phase enable.
module cs0_wait_gen
    import cs0_sched_pkg::*;
#(
    parameter logic [3:0] DRAM_WS = DRAM_WS_DEF,
    parameter logic [3:0] ROM_WS  = ROM_WS_DEF
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         res_n_i,
    input  logic         ce_r_i,
    input  logic         ce_f_i,
    input  logic [24:21] a_i,
    input  logic         cs0_n_i,
    input  logic         strb_n_i,
    input  logic         fast_i,
    output logic         wait_n_o,
    output logic         idle_o
);

    logic       strb_prev_q;
    logic [3:0] cnt_q, cnt_d;
    logic       wait_n_q, wait_n_d;
    logic       start;

    assign start = strb_prev_q & ~strb_n_i & ~cs0_n_i;

    always_comb begin
        cnt_d    = cnt_q;
        wait_n_d = wait_n_q;
        if (start && !fast_i) begin
            // a restart while counting simply reloads
            cnt_d    = (a_i == LWRAM_A) ? ws_load(DRAM_WS) : ws_load(ROM_WS);
            wait_n_d = 1'b0;
        end else begin
            if (ce_f_i && cnt_q == 4'd0)
                wait_n_d = 1'b1;
            if (ce_r_i && cnt_q != 4'd0)
                cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            strb_prev_q <= 1'b1;
            cnt_q       <= 4'd0;
            wait_n_q    <= 1'b1;
        end else if (!res_n_i) begin
            strb_prev_q <= 1'b1;
            cnt_q       <= 4'd0;
            wait_n_q    <= 1'b1;
        end else begin
            strb_prev_q <= strb_n_i;
            cnt_q       <= cnt_d;
            wait_n_q    <= wait_n_d;
        end
    end

    assign wait_n_o = wait_n_q;
    assign idle_o   = (cnt_q == 4'd0);

endmodule

// File: rtl/cs0_bus_sched.sv
// CS0 bus scheduler: hands the bus from the master SH-2 to the slave SH-2 or SCU and back.
// Optional build macro CS0_ARB_RR_EN selects round-robin tie breaking in MST.
module cs0_bus_sched
    import cs0_sched_pkg::*;
#(
    parameter logic [3:0] DRAM_WS  = DRAM_WS_DEF,
    parameter logic [3:0] ROM_WS   = ROM_WS_DEF,
    parameter logic [7:0] HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         ce_r_i,
    input  logic         ce_f_i,
    input  logic         res_n_i,
    input  logic         sreq_n_i,
    input  logic         xreq_n_i,
    input  logic         bgr_n_i,
    output logic         brls_n_o,
    output logic         sack_n_o,
    output logic         xack_n_o,
    output logic [1:0]   owner_o,
    input  logic [24:21] a_i,
    input  logic         cs0_n_i,
    input  logic         strb_n_i,
    input  logic         fast_i,
    output logic         wait_n_o
);

    owner_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       left_scu_q, left_scu_d;
    logic       brls_n_q, sack_n_q, xack_n_q;
    logic       wait_idle, tie_scu;
    logic       s_pend, x_pend, own_pend, oth_pend, hold_full;

    cs0_wait_gen #(
        .DRAM_WS (DRAM_WS),
        .ROM_WS  (ROM_WS)
    ) u_wait (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .res_n_i  (res_n_i),
        .ce_r_i   (ce_r_i),
        .ce_f_i   (ce_f_i),
        .a_i      (a_i),
        .cs0_n_i  (cs0_n_i),
        .strb_n_i (strb_n_i),
        .fast_i   (fast_i),
        .wait_n_o (wait_n_o),
        .idle_o   (wait_idle)
    );

    always_comb begin
        s_pend     = ~sreq_n_i;
        x_pend     = ~xreq_n_i;
        own_pend   = (state_q == SCU) ? x_pend : s_pend;
        oth_pend   = (state_q == SCU) ? s_pend : x_pend;
        hold_full  = (hold_q == HOLD_MAX);
        state_d    = state_q;
        hold_d     = hold_q;
        left_scu_d = left_scu_q;
        case (state_q)
            MST: begin
                if ((s_pend || x_pend) && !bgr_n_i)
                    state_d = (s_pend && !(x_pend && tie_scu)) ? SSH : SCU;
            end
            SSH, SCU: begin
                // forced handover only between accesses
                if (!own_pend || (hold_full && strb_n_i && wait_idle)) begin
                    state_d    = GAP;
                    hold_d     = 8'd0;
                    left_scu_d = (state_q == SCU);
                end else if (oth_pend && !hold_full) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            GAP: begin
                if ((left_scu_q ? s_pend : x_pend) && !bgr_n_i)
                    state_d = left_scu_q ? SSH : SCU;
                else if (left_scu_q ? x_pend : s_pend)
                    state_d = left_scu_q ? SCU : SSH;
                else
                    state_d = MST;
            end
            default: state_d = MST;
        endcase
    end

`ifdef CS0_ARB_RR_EN
    logic last_scu_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            last_scu_q <= 1'b1;
        else if (!res_n_i)
            last_scu_q <= 1'b1;
        else if (ce_r_i && (state_q == MST || state_q == GAP) &&
                 (state_d == SSH || state_d == SCU))
            last_scu_q <= (state_d == SCU);
    end

    assign tie_scu = ~last_scu_q;
`else
    assign tie_scu = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= MST;
            hold_q     <= 8'd0;
            left_scu_q <= 1'b0;
            brls_n_q   <= 1'b1;
            sack_n_q   <= 1'b1;
            xack_n_q   <= 1'b1;
        end else if (!res_n_i) begin
            state_q    <= MST;
            hold_q     <= 8'd0;
            left_scu_q <= 1'b0;
            brls_n_q   <= 1'b1;
            sack_n_q   <= 1'b1;
            xack_n_q   <= 1'b1;
        end else if (ce_r_i) begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            left_scu_q <= left_scu_d;
            brls_n_q   <= (state_d == MST) ? (sreq_n_i & xreq_n_i) : 1'b0;
            // acknowledge one enable after entry, drop together with the exit
            sack_n_q   <= ~(state_q == SSH && state_d == SSH);
            xack_n_q   <= ~(state_q == SCU && state_d == SCU);
        end
    end

    assign brls_n_o = brls_n_q;
    assign sack_n_o = sack_n_q;
    assign xack_n_o = xack_n_q;
    assign owner_o  = state_q;

endmodule
